// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
// Bit-serial adder controller: walks one shared full-adder cell (two half
// adders plus an OR) across a WIDTH-bit operand pair, LSB first, one bit per
// clock. Owns operand capture, bit counter, carry flop and result register.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request; sampled only while idle
//   a, b   operands, captured on the accepting edge
//   busy   high from acceptance until the cycle after done
//   done   one-cycle pulse, sum/cout hold a new result
//   sum    last completed result, held between operations
//   cout   carry out of bit WIDTH-1 of the last completed result
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // One extra bit so the post-exit increment never aliases back to 0.
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, a_sr_nxt;
    logic [WIDTH-1:0] b_sr, b_sr_nxt;
    logic [WIDTH-1:0] res_sr, res_sr_nxt;
    logic             carry, carry_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic [WIDTH-1:0] sum_nxt;
    logic             cout_nxt;

    logic [1:0]       ha_lo;
    logic [1:0]       ha_hi;
    logic             ser_bit;
    logic             cell_carry;
    logic [WIDTH-1:0] res_shift;

    // Half adder: {carry, sum}.
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            state  <= state_nxt;
            a_sr   <= a_sr_nxt;
            b_sr   <= b_sr_nxt;
            res_sr <= res_sr_nxt;
            carry  <= carry_nxt;
            cnt    <= cnt_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
            sum    <= sum_nxt;
            cout   <= cout_nxt;
        end
    end

    // Next-state, shared adder cell and registered-output next values.
    always_comb begin
        state_nxt  = state;
        a_sr_nxt   = a_sr;
        b_sr_nxt   = b_sr;
        res_sr_nxt = res_sr;
        carry_nxt  = carry;
        cnt_nxt    = cnt;
        busy_nxt   = busy;
        done_nxt   = 1'b0;
        sum_nxt    = sum;
        cout_nxt   = cout;

        // The single full-adder cell, built from two half adders.
        ha_lo      = half_add(a_sr[0], b_sr[0]);
        ha_hi      = half_add(ha_lo[0], carry);
        ser_bit    = ha_hi[0];
        cell_carry = ha_lo[1] | ha_hi[1];

        // Right shift with the new bit entering at the MSB; written as a
        // shift so it stays legal for WIDTH == 1.
        res_shift  = (res_sr >> 1) | (WIDTH'(ser_bit) << (WIDTH - 1));

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    a_sr_nxt  = a;
                    b_sr_nxt  = b;
                    carry_nxt = 1'b0;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b1;
                end
            end
            RUN: begin
                a_sr_nxt   = a_sr >> 1;
                b_sr_nxt   = b_sr >> 1;
                res_sr_nxt = res_shift;
                carry_nxt  = cell_carry;
                cnt_nxt    = cnt + CW'(1);
                // Last bit: publish the full result in one step so partial
                // sums are never visible on the outputs.
                if (cnt == CW'(WIDTH - 1)) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                    sum_nxt   = res_shift;
                    cout_nxt  = cell_carry;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: an 8-bit and a 1-bit instance share clk/rst_n.
// A timing model per instance pushes a+b into a queue at each accepting edge
// and pops it into the expected result when done is due; every falling edge
// compares busy/done/{cout,sum} against the model. Directed steps add
// latency, busy-length and hold checks against fixed constants.
module tb_serial_adder_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int n_assert = 0;
    int n_fail   = 0;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference timing models: 0 idle, 1 run, 2 done.
    logic [1:0] m8_state;
    int         m8_cnt;
    logic [8:0] q8[$];
    logic [8:0] m8_out;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m8_state <= 2'd0;
            m8_cnt   <= 0;
            m8_out   <= '0;
            q8.delete();
        end else begin
            case (m8_state)
                2'd0: if (start) begin
                    q8.push_back(9'(a) + 9'(b));
                    m8_state <= 2'd1;
                    m8_cnt   <= 0;
                end
                2'd1: if (m8_cnt == 7) begin
                    m8_state <= 2'd2;
                    if (q8.size() > 0) m8_out <= q8.pop_front();
                    else chk("queue8_empty", 32'd1, 32'd0);
                end else begin
                    m8_cnt <= m8_cnt + 1;
                end
                default: m8_state <= 2'd0;
            endcase
        end
    end

    logic [1:0] m1_state;
    logic [1:0] q1[$];
    logic [1:0] m1_out;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1_state <= 2'd0;
            m1_out   <= '0;
            q1.delete();
        end else begin
            case (m1_state)
                2'd0: if (start1) begin
                    q1.push_back(2'(a1) + 2'(b1));
                    m1_state <= 2'd1;
                end
                2'd1: begin
                    m1_state <= 2'd2;
                    if (q1.size() > 0) m1_out <= q1.pop_front();
                    else chk("queue1_empty", 32'd1, 32'd0);
                end
                default: m1_state <= 2'd0;
            endcase
        end
    end

    // Per-cycle scoreboard comparison, away from the active edge.
    always @(negedge clk) begin
        chk("busy8", 32'(busy), 32'(m8_state != 2'd0));
        chk("done8", 32'(done), 32'(m8_state == 2'd2));
        chk("res8",  32'({cout, sum}), 32'(m8_out));
        chk("busy1", 32'(busy1), 32'(m1_state != 2'd0));
        chk("done1", 32'(done1), 32'(m1_state == 2'd2));
        chk("res1",  32'({cout1, sum1}), 32'(m1_out));
    end

    // One 8-bit operation: pulse start, watch 12 cycles.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic [7:0] hold,
                          output int didx, output int bcnt, output logic [8:0] res,
                          output logic hold_ok);
        @(negedge clk);
        start = 1'b1; a = ta; b = tb;
        didx = -1; bcnt = 0; res = 'x; hold_ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) bcnt++;
            if (done) begin
                didx = i;
                res  = {cout, sum};
            end else if (didx < 0 && sum !== hold) begin
                hold_ok = 1'b0;
            end
        end
    endtask

    int         didx;
    int         bcnt;
    int         ndone;
    logic [8:0] res;
    logic       hold_ok;

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        start1 = 1'b0; a1 = '0; b1 = '0;

        // Reset then idle.
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_res",  32'({cout, sum}), 32'h000);

        // Carry ripple through all bits.
        run_op(8'hFF, 8'h01, 8'h00, didx, bcnt, res, hold_ok);
        chk("ripple_latency", 32'(didx), 32'd8);
        chk("ripple_busy",    32'(bcnt), 32'd9);
        chk("ripple_res",     32'(res),  32'h100);

        // No carry, then MSB carry with hold of previous sum.
        run_op(8'hA5, 8'h5A, 8'h00, didx, bcnt, res, hold_ok);
        chk("mixed_res", 32'(res), 32'h0FF);
        run_op(8'h80, 8'h80, 8'hFF, didx, bcnt, res, hold_ok);
        chk("msb_res",   32'(res), 32'h100);
        chk("msb_hold",  32'(hold_ok), 32'd1);

        // Start while busy is ignored.
        @(negedge clk);
        start = 1'b1; a = 8'h03; b = 8'h04;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = ((i >= 2 && i <= 4) || i == 8);
            a = 8'hFF; b = 8'hFF;
            if (done) begin
                ndone++;
                res = {cout, sum};
            end
        end
        chk("busy_start_dones", 32'(ndone), 32'd1);
        chk("busy_start_res",   32'(res),   32'h007);

        // Reset mid-operation.
        @(negedge clk);
        start = 1'b1; a = 8'h7F; b = 8'h01;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_res",  32'({cout, sum}), 32'h000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h10, 8'h20, 8'h00, didx, bcnt, res, hold_ok);
        chk("post_rst_latency", 32'(didx), 32'd8);
        chk("post_rst_res",     32'(res),  32'h030);
        chk("post_rst_hold",    32'(hold_ok), 32'd1);

        // Back-to-back random, start held high.
        @(negedge clk);
        ndone = 0;
        start = 1'b1; a = 8'($urandom); b = 8'($urandom);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) ndone++;
            a = 8'($urandom); b = 8'($urandom);
        end
        start = 1'b0;
        chk("b2b_dones", 32'(ndone), 32'd20);
        repeat (12) @(negedge clk);

        // WIDTH=1: cycle through all four operand pairs back-to-back.
        ndone = 0;
        start1 = 1'b1; a1 = 1'b0; b1 = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (done1) ndone++;
            a1 = 1'((i + 1) >> 1);
            b1 = 1'(i + 1);
        end
        start1 = 1'b0;
        chk("w1_dones", 32'(ndone), 32'd8);
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller that sequences one shared full-adder cell over a WIDTH-bit operand pair, one bit per clock, LSB first. The cell is built from two half adders plus an OR. The block owns operand capture, the bit counter, the carry flop and the result register. It sits between a requester that issues start/operands and the single adder cell, trading latency for area in place of WIDTH parallel adder cells.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 1..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse or level; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- busy  output  1  high while a request is accepted and not yet completed (RUN and DONE).
- done  output  1  one-cycle pulse: sum/cout hold a new result.
- sum  output  WIDTH  last completed result; held between operations.
- cout  output  1  carry out of bit WIDTH-1 of the last completed result.

## Operation
- States:
  - IDLE: waits for start.
  - RUN: processes one bit per cycle.
  - DONE: single cycle, done=1.
- IDLE -> RUN:
  - Taken when start=1 at the clock edge.
  - On that edge: latch a and b into internal shift registers, clear the carry flop, clear the bit counter to 0.
- RUN, each edge:
  - Cell input is a_sr[0], b_sr[0], carry.
  - Serial bit = a_sr[0] ^ b_sr[0] ^ carry.
  - New carry = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0])).
  - Shift the serial bit into the MSB of the internal result shift register (right shift).
  - Shift a_sr and b_sr right by one.
  - Update the carry flop with the new carry.
  - Increment the counter.
- RUN -> DONE:
  - Taken on the edge that processes bit WIDTH-1, i.e. when counter == WIDTH-1 before that edge.
  - On the same edge, sum <= completed result register and cout <= new carry.
- DONE -> IDLE: unconditionally on the next edge.
- start handling:
  - Ignored in RUN and DONE; no queuing.
  - A start still high on the first IDLE edge begins a new operation with the operands present at that edge.
- sum and cout are not disturbed during RUN. Intermediate partial results are never visible.
- Arithmetic:
  - Unsigned modulo-2^WIDTH sum.
  - cout is the WIDTH-th bit.
  - {cout,sum} == a + b, using the values captured at acceptance.
- Counter width is clog2(WIDTH)+1 bits. No wrap can occur before the RUN exit.
- Reset (rst_n=0, at any time including mid-RUN):
  - State goes to IDLE immediately.
  - busy=0, done=0, sum=0, cout=0.
  - Counter, carry and shift registers cleared.
  - The in-flight operation is discarded, with no done pulse.
- Reset release: the first edge with rst_n=1 may accept start.

## Timing
- Accepting edge E0: start=1 in IDLE.
- busy rises after E0.
- Bits 0..WIDTH-1 are processed on edges E1..E_WIDTH.
- sum, cout and done update after edge E_WIDTH.
- done=1 for exactly the cycle between E_WIDTH and E_WIDTH+1.
- busy falls after E_WIDTH+1.
- Latency: start to done = WIDTH cycles. Minimum issue interval = WIDTH+2 cycles, since a new start is next accepted at E_WIDTH+2.
- WIDTH=1: RUN lasts one cycle, and done follows E1.
- All outputs are registered. No combinational path from start, a or b to any output.

## Test plan
- Reset then idle: hold rst_n=0 for 2 cycles, then release; start=0 for 5 cycles -> busy=0, done=0, sum=8'h00, cout=0 throughout.
- Carry ripple: WIDTH=8, a=8'hFF, b=8'h01, start for 1 cycle -> done exactly 8 cycles after the accepting edge; sum=8'h00, cout=1; busy high for 9 cycles.
- No carry / mixed: a=8'hA5, b=8'h5A -> sum=8'hFF, cout=0. Then a=8'h80, b=8'h80 -> sum=8'h00, cout=1. During the second operation, sum must hold 8'hFF until its done.
- Start while busy: accept a=8'h03, b=8'h04; assert start with a=8'hFF, b=8'hFF during cycles 3..5 of RUN and in DONE -> a single done, sum=8'h07, cout=0, no second operation.
- Reset mid-operation: accept a=8'h7F, b=8'h01; drop rst_n at RUN cycle 4 -> outputs 0 immediately, no done. After release, a=8'h10, b=8'h20 -> sum=8'h30 after 8 cycles.
- Back-to-back and random: hold start=1 continuously for 200 cycles with a new random a and b each cycle -> a done every 10 cycles; each {cout,sum} equals the sum of the operands sampled at its accepting edge. Repeat with WIDTH=1 and all 4 input pairs.
